// File: rtl/des_pkg.sv
// DES key schedule shared definitions: FIPS 46-3 permutation tables,
// per-round shift table, FSM state type and width constants.
// Right-rotate helper exists only with DES_KS_DECRYPT_EN.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned CD_W     = 2 * HALF_W;
  localparam int unsigned ROUNDS   = 16;

  typedef enum logic {
    IDLE,
    RUN
  } ks_state_t;

  // PC-1: entry i gives the FIPS key bit (1 = MSB) feeding output bit i+1
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i gives the C||D bit (1 = MSB) feeding subkey bit i+1
  localparam int unsigned PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied before round i (0-based)
  localparam int unsigned SHIFT_TAB [ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic logic shift_two(input logic [3:0] idx);
    return SHIFT_TAB[idx] == 2;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x,
                                             input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
               : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

`ifdef DES_KS_DECRYPT_EN
  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x,
                                             input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]}
               : {x[0], x[HALF_W-1:1]};
  endfunction
`endif

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: 56-bit C||D in, 48-bit round key out.
// Purely combinational wiring.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] k
);

  // Select each subkey bit from its table position in C||D
  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < SUBKEY_W; i++) begin
      k[SUBKEY_W-1-i] = cd[CD_W-PC2_TAB[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: accepts a 64-bit key, then streams the 16 round keys
// with a valid/ready handshake. Optional macro DES_KS_DECRYPT_EN adds a
// decrypt input that emits K16..K1 by rotating C/D right.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                key_valid,
  output logic                key_ready,
`ifdef DES_KS_DECRYPT_EN
  input  logic                decrypt,
`endif
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          round_idx,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic                subkey_last
);

  ks_state_t         state, state_nxt;
  logic [HALF_W-1:0] c_q, d_q, c_nxt, d_nxt;
  logic [3:0]        round_q;
  logic [CD_W-1:0]   pc1;
  logic              load, adv, last_rnd;
  logic              unused_parity;
`ifdef DES_KS_DECRYPT_EN
  logic              dec_q;
`endif

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign last_rnd = (round_q == 4'd15);
  assign load     = key_valid && (state == IDLE);
  assign adv      = subkey_ready && (state == RUN);

  // PC-1: gather the 56 non-parity key bits into C||D order
  always_comb begin
    pc1 = '0;
    for (int unsigned i = 0; i < CD_W; i++) begin
      pc1[CD_W-1-i] = key_in[KEY_W-PC1_TAB[i]];
    end
  end

  // Next C/D: load pre-rotated for round 0, then rotate per handshake.
  // The final handshake leaves C/D alone: the 16 encrypt rotations sum to
  // 28, so the registers already hold the unrotated PC-1 value.
  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (load) begin
      c_nxt = rotl(pc1[CD_W-1:HALF_W], 1'b0);
      d_nxt = rotl(pc1[HALF_W-1:0], 1'b0);
`ifdef DES_KS_DECRYPT_EN
      if (decrypt) begin
        c_nxt = pc1[CD_W-1:HALF_W];
        d_nxt = pc1[HALF_W-1:0];
      end
`endif
    end else if (adv && !last_rnd) begin
      c_nxt = rotl(c_q, shift_two(round_q + 4'd1));
      d_nxt = rotl(d_q, shift_two(round_q + 4'd1));
`ifdef DES_KS_DECRYPT_EN
      if (dec_q) begin
        c_nxt = rotr(c_q, shift_two(4'd15 - round_q));
        d_nxt = rotr(d_q, shift_two(4'd15 - round_q));
      end
`endif
    end
  end

  // Datapath registers: C/D halves, round counter, direction
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
`ifdef DES_KS_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      c_q <= c_nxt;
      d_q <= d_nxt;
      if (load) begin
        round_q <= '0;
`ifdef DES_KS_DECRYPT_EN
        dec_q   <= decrypt;
`endif
      end else if (adv) begin
        round_q <= round_q + 4'd1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: IDLE -> RUN on key accept, RUN -> IDLE after round 15
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_valid) state_nxt = RUN;
      RUN:     if (subkey_ready && last_rnd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    key_ready    = (state == IDLE);
    subkey_valid = (state == RUN);
    subkey_last  = (state == RUN) && last_rnd;
    round_idx    = round_q;
  end

  des_pc2 u_pc2 (
    .cd ({c_q, d_q}),
    .k  (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: an independent DES subkey model
// fills a queue at key acceptance; entries are popped on each handshake.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PAR = 64'h133557799BBDDFF1;
  localparam logic [63:0] KEY_B   = 64'h123456789ABCDEF0;

  localparam int unsigned M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned M_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        key_valid;
  logic        key_ready;
`ifdef DES_KS_DECRYPT_EN
  logic        decrypt;
`endif
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        subkey_last;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
`ifdef DES_KS_DECRYPT_EN
    .decrypt      (decrypt),
`endif
    .subkey       (subkey),
    .round_idx    (round_idx),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey_last  (subkey_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Kn (n = 1..16) from the cumulative left shift applied to PC-1(key)
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int unsigned n);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < 56; i++) cd[55-i] = key[64-M_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int unsigned i = 0; i < n; i++) s += M_SH[i];
    s = s % 28;
    for (int unsigned j = 0; j < s; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int unsigned i = 0; i < 48; i++) k[47-i] = cd[56-M_PC2[i]];
    return k;
  endfunction

  // kat: 0 model only, 1 published encrypt values, 2 published decrypt values
  function automatic void push_key(input logic [63:0] key, input logic dec, input int kat);
    exp_t e;
    for (int unsigned r = 0; r < 16; r++) begin
      e.sk   = ref_subkey(key, dec ? 16 - r : r + 1);
      e.idx  = 4'(r);
      e.last = (r == 15);
      if (kat == 1 && r == 0)  e.sk = 48'h1B02EFFC7072;
      if (kat == 1 && r == 1)  e.sk = 48'h79AED9DBC9E5;
      if (kat == 1 && r == 15) e.sk = 48'hCB3D8B0E17F5;
      if (kat == 2 && r == 0)  e.sk = 48'hCB3D8B0E17F5;
      if (kat == 2 && r == 15) e.sk = 48'h1B02EFFC7072;
      sbq.push_back(e);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first output cycle
  task automatic offer_key(input logic [63:0] key, input logic dec, input int kat);
    int unsigned n;
    n = 0;
    while (!key_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("key_ready_wait", key_ready, 1);
    key_in    = key;
    key_valid = 1'b1;
`ifdef DES_KS_DECRYPT_EN
    decrypt   = dec;
`endif
    @(posedge clk); #1;
    key_valid = 1'b0;
    push_key(key, dec, kat);
    check("lat_valid", subkey_valid, 1);
    check("lat_idx", round_idx, 0);
  endtask

  // Drain the scoreboard; optionally hold a second key on key_valid from
  // round 3 on, which must only be taken once the block is back in IDLE.
  task automatic run(input logic rnd, input logic pend, input logic [63:0] pkey,
                     input logic pdec);
    exp_t        e;
    int unsigned hs;
    int unsigned cyc;
    hs  = 0;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 400) begin
      subkey_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pend && hs >= 3) begin
        key_in    = pkey;
        key_valid = 1'b1;
`ifdef DES_KS_DECRYPT_EN
        decrypt   = pdec;
`endif
      end
      @(negedge clk);
      if (key_valid) check("busy_key_ready", key_ready, 0);
      check("valid", subkey_valid, 1);
      if (subkey_ready) begin
        e = sbq.pop_front();
        check("subkey", subkey, e.sk);
        check("round_idx", round_idx, e.idx);
        check("last", subkey_last, e.last);
        hs++;
      end else begin
        check("hold_subkey", subkey, sbq[0].sk);
        check("hold_idx", round_idx, sbq[0].idx);
        check("hold_last", subkey_last, sbq[0].last);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("drain", sbq.size(), 0);
    check("end_valid", subkey_valid, 0);
    check("end_key_ready", key_ready, 1);
    if (pend) begin
      @(posedge clk); #1;
      key_valid = 1'b0;
      push_key(pkey, pdec, 0);
      check("pend_valid", subkey_valid, 1);
      check("pend_idx", round_idx, 0);
    end
  endtask

  initial begin
    exp_t e;
    int unsigned cyc;
    rst          = 1'b1;
    key_in       = KEY_STD;
    key_valid    = 1'b1;
    subkey_ready = 1'b1;
`ifdef DES_KS_DECRYPT_EN
    decrypt      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ready", key_ready, 1);
    check("rst_valid", subkey_valid, 0);
    check("rst_subkey", subkey, 0);
    check("rst_last", subkey_last, 0);
    check("rst_idx", round_idx, 0);
    rst       = 1'b0;
    key_valid = 1'b0;
    @(posedge clk); #1;

    // Published key, always-ready: 16 back-to-back subkeys
    offer_key(KEY_STD, 1'b0, 1);
    run(1'b0, 1'b0, '0, 1'b0);

    // Same key under random backpressure
    offer_key(KEY_STD, 1'b0, 1);
    run(1'b1, 1'b0, '0, 1'b0);

    // Key offered during RUN is held off until IDLE
    offer_key(KEY_STD, 1'b0, 1);
    run(1'b1, 1'b1, KEY_B, 1'b0);
    run(1'b0, 1'b0, '0, 1'b0);

    // Parity bits are ignored: flipped-parity key gives published values
    offer_key(KEY_PAR, 1'b0, 1);
    run(1'b1, 1'b0, '0, 1'b0);

    // Reset in the middle of a run, with key_valid also high
    offer_key(KEY_B, 1'b0, 0);
    subkey_ready = 1'b1;
    cyc = 0;
    while (round_idx != 4'd7 && cyc < 40) begin
      @(negedge clk);
      if (round_idx != 4'd7) begin
        e = sbq.pop_front();
        check("pre_rst_subkey", subkey, e.sk);
        @(posedge clk); #1;
      end
      cyc++;
    end
    check("reach_round7", round_idx, 7);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_in    = KEY_STD;
    @(posedge clk); #1;
    rst       = 1'b0;
    key_valid = 1'b0;
    check("mid_rst_valid", subkey_valid, 0);
    check("mid_rst_key_ready", key_ready, 1);
    check("mid_rst_subkey", subkey, 0);
    check("mid_rst_idx", round_idx, 0);
    check("mid_rst_last", subkey_last, 0);
    sbq.delete();
    @(posedge clk); #1;
    offer_key(KEY_STD, 1'b0, 1);
    run(1'b0, 1'b0, '0, 1'b0);

`ifdef DES_KS_DECRYPT_EN
    // Reverse order K16..K1, then back to encrypt
    offer_key(KEY_STD, 1'b1, 2);
    run(1'b1, 1'b0, '0, 1'b0);
    offer_key(KEY_B, 1'b1, 0);
    run(1'b1, 1'b1, KEY_STD, 1'b0);
    run(1'b0, 1'b0, '0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
